// File: rtl/apb_target_demux_pkg.sv
// ----------------------------------------------------------------------------
// apb_target_demux_pkg
//   Shared definitions for the APB one-master / four-target demultiplexer:
//   bus widths, target-select bit positions, access timeout length, the FSM
//   state encoding and the address-to-target decode helper.
// ----------------------------------------------------------------------------
package apb_target_demux_pkg;

    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;
    localparam int NUM_TARGETS = 4;
    localparam int SEL_W       = 2;

    // Target index lives in paddr[SEL_MSB:SEL_LSB]
    localparam int SEL_MSB = 13;
    localparam int SEL_LSB = 12;

    // Access timeout: the counter is 8 bits wide and gives up at 255
    localparam int                 TIMER_W        = 8;
    localparam logic [TIMER_W-1:0] TIMEOUT_CYCLES = 8'd255;
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST   = TIMEOUT_CYCLES - 8'd1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_ACCESS  = 2'd2,
        ST_RESPOND = 2'd3
    } state_t;

    function automatic logic [SEL_W-1:0] target_index(input logic [ADDR_W-1:0] addr);
        return addr[SEL_MSB:SEL_LSB];
    endfunction

endpackage

// File: rtl/apb_access_timer.sv
// ----------------------------------------------------------------------------
// apb_access_timer
//   Counts ACCESS-phase cycles and flags the cycle on which the count would
//   reach TIMEOUT_CYCLES, so the FSM can leave ACCESS on that same edge.
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-high reset
//   i_start   in   zero the counter (entry into ACCESS)
//   i_enable  in   count one ACCESS cycle (already qualified by clock enable)
//   i_clear   in   zero the counter (transaction finished)
//   o_expired out  high in the ACCESS cycle whose edge reaches the timeout
// ----------------------------------------------------------------------------
module apb_access_timer
    import apb_target_demux_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_start,
    input  logic i_enable,
    input  logic i_clear,
    output logic o_expired
);

    logic [TIMER_W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_start || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    // r_count holds the number of ACCESS cycles already completed, so the
    // 255th ACCESS cycle is the one where the count equals 254.
    assign o_expired = i_enable && (r_count == TIMEOUT_LAST);

endmodule

// File: rtl/apb_target_demux.sv
// ----------------------------------------------------------------------------
// apb_target_demux
//   Routes single-master APB transfers to one of four targets selected by
//   paddr[13:12]. The upstream request is registered in IDLE, replayed to the
//   selected target as SETUP/ACCESS, and the target's answer (or a timeout
//   error after 255 ACCESS cycles) is returned upstream as a one-cycle pready.
//
// Ports
//   clk, clk__enable, reset               clock, clock enable, async reset
//   apb_request__*   (in)                 upstream master request
//   apb_response__*  (out)                response to the upstream master
//   apb_request_N__* (out, N=0..3)        request to target N
//   apb_response_N__*(in,  N=0..3)        response from target N
// ----------------------------------------------------------------------------
module apb_target_demux
    import apb_target_demux_pkg::*;
(
    input  logic              clk,
    input  logic              clk__enable,
    input  logic              reset,

    input  logic [ADDR_W-1:0] apb_request__paddr,
    input  logic              apb_request__penable,
    input  logic              apb_request__psel,
    input  logic              apb_request__pwrite,
    input  logic [DATA_W-1:0] apb_request__pwdata,

    output logic [DATA_W-1:0] apb_response__prdata,
    output logic              apb_response__pready,
    output logic              apb_response__perr,

    output logic [ADDR_W-1:0] apb_request_0__paddr,
    output logic              apb_request_0__penable,
    output logic              apb_request_0__psel,
    output logic              apb_request_0__pwrite,
    output logic [DATA_W-1:0] apb_request_0__pwdata,
    input  logic [DATA_W-1:0] apb_response_0__prdata,
    input  logic              apb_response_0__pready,
    input  logic              apb_response_0__perr,

    output logic [ADDR_W-1:0] apb_request_1__paddr,
    output logic              apb_request_1__penable,
    output logic              apb_request_1__psel,
    output logic              apb_request_1__pwrite,
    output logic [DATA_W-1:0] apb_request_1__pwdata,
    input  logic [DATA_W-1:0] apb_response_1__prdata,
    input  logic              apb_response_1__pready,
    input  logic              apb_response_1__perr,

    output logic [ADDR_W-1:0] apb_request_2__paddr,
    output logic              apb_request_2__penable,
    output logic              apb_request_2__psel,
    output logic              apb_request_2__pwrite,
    output logic [DATA_W-1:0] apb_request_2__pwdata,
    input  logic [DATA_W-1:0] apb_response_2__prdata,
    input  logic              apb_response_2__pready,
    input  logic              apb_response_2__perr,

    output logic [ADDR_W-1:0] apb_request_3__paddr,
    output logic              apb_request_3__penable,
    output logic              apb_request_3__psel,
    output logic              apb_request_3__pwrite,
    output logic [DATA_W-1:0] apb_request_3__pwdata,
    input  logic [DATA_W-1:0] apb_response_3__prdata,
    input  logic              apb_response_3__pready,
    input  logic              apb_response_3__perr
);

    state_t r_state;
    state_t w_next_state;

    logic [ADDR_W-1:0]      r_paddr;
    logic                   r_pwrite;
    logic [DATA_W-1:0]      r_pwdata;
    logic [SEL_W-1:0]       r_sel;
    logic [DATA_W-1:0]      r_prdata;
    logic                   r_perr;

    logic                   w_capture_req;
    logic                   w_capture_rsp;
    logic                   w_timeout;
    logic                   w_tgt_psel;
    logic                   w_tgt_penable;
    logic [NUM_TARGETS-1:0] w_sel_onehot;
    logic [NUM_TARGETS-1:0] w_psel;
    logic [NUM_TARGETS-1:0] w_penable;

    logic                   w_sel_pready;
    logic [DATA_W-1:0]      w_sel_prdata;
    logic                   w_sel_perr;
    logic                   w_expired;

    logic                   w_timer_start;
    logic                   w_timer_enable;
    logic                   w_timer_clear;

    // The master's penable carries no information this block needs: the
    // transfer is captured on psel alone while IDLE.
    logic                   w_unused_penable;
    assign w_unused_penable = apb_request__penable;

    // Only the selected target's response is looked at; the others are
    // free to show anything.
    always_comb begin
        w_sel_pready = 1'b0;
        w_sel_prdata = '0;
        w_sel_perr   = 1'b0;
        case (r_sel)
            2'd0: begin
                w_sel_pready = apb_response_0__pready;
                w_sel_prdata = apb_response_0__prdata;
                w_sel_perr   = apb_response_0__perr;
            end
            2'd1: begin
                w_sel_pready = apb_response_1__pready;
                w_sel_prdata = apb_response_1__prdata;
                w_sel_perr   = apb_response_1__perr;
            end
            2'd2: begin
                w_sel_pready = apb_response_2__pready;
                w_sel_prdata = apb_response_2__prdata;
                w_sel_perr   = apb_response_2__perr;
            end
            default: begin
                w_sel_pready = apb_response_3__pready;
                w_sel_prdata = apb_response_3__prdata;
                w_sel_perr   = apb_response_3__perr;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else if (clk__enable) begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_capture_req = 1'b0;
        w_capture_rsp = 1'b0;
        w_timeout     = 1'b0;
        w_tgt_psel    = 1'b0;
        w_tgt_penable = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (apb_request__psel) begin
                    w_capture_req = 1'b1;
                    w_next_state  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_tgt_psel   = 1'b1;
                w_next_state = ST_ACCESS;
            end
            ST_ACCESS: begin
                w_tgt_psel    = 1'b1;
                w_tgt_penable = 1'b1;
                // A real answer beats a timeout landing on the same edge
                if (w_sel_pready) begin
                    w_capture_rsp = 1'b1;
                    w_next_state  = ST_RESPOND;
                end else if (w_expired) begin
                    w_timeout    = 1'b1;
                    w_next_state = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_paddr  <= '0;
            r_pwrite <= 1'b0;
            r_pwdata <= '0;
            r_sel    <= '0;
            r_prdata <= '0;
            r_perr   <= 1'b0;
        end else if (clk__enable) begin
            if (w_capture_req) begin
                r_paddr  <= apb_request__paddr;
                r_pwrite <= apb_request__pwrite;
                r_pwdata <= apb_request__pwdata;
                r_sel    <= target_index(apb_request__paddr);
            end
            if (w_capture_rsp) begin
                r_prdata <= w_sel_prdata;
                r_perr   <= w_sel_perr;
            end else if (w_timeout) begin
                r_prdata <= '0;
                r_perr   <= 1'b1;
            end
        end
    end

    // Timer controls are qualified by the clock enable so a frozen clock
    // also freezes the count.
    assign w_timer_start  = clk__enable && (r_state == ST_SETUP);
    assign w_timer_enable = clk__enable && (r_state == ST_ACCESS);
    assign w_timer_clear  = clk__enable && (r_state == ST_RESPOND);

    apb_access_timer u_timer (
        .clk       (clk),
        .reset     (reset),
        .i_start   (w_timer_start),
        .i_enable  (w_timer_enable),
        .i_clear   (w_timer_clear),
        .o_expired (w_expired)
    );

    // psel/penable are decoded straight from the state register, so the
    // asynchronous reset drops them without waiting for a clock edge.
    always_comb begin
        w_sel_onehot        = '0;
        w_sel_onehot[r_sel] = 1'b1;
    end

    assign w_psel    = w_tgt_psel    ? w_sel_onehot : '0;
    assign w_penable = w_tgt_penable ? w_sel_onehot : '0;

    assign apb_response__prdata = r_prdata;
    assign apb_response__perr   = r_perr;
    assign apb_response__pready = (r_state == ST_RESPOND);

    assign apb_request_0__paddr   = r_paddr;
    assign apb_request_0__pwrite  = r_pwrite;
    assign apb_request_0__pwdata  = r_pwdata;
    assign apb_request_0__psel    = w_psel[0];
    assign apb_request_0__penable = w_penable[0];

    assign apb_request_1__paddr   = r_paddr;
    assign apb_request_1__pwrite  = r_pwrite;
    assign apb_request_1__pwdata  = r_pwdata;
    assign apb_request_1__psel    = w_psel[1];
    assign apb_request_1__penable = w_penable[1];

    assign apb_request_2__paddr   = r_paddr;
    assign apb_request_2__pwrite  = r_pwrite;
    assign apb_request_2__pwdata  = r_pwdata;
    assign apb_request_2__psel    = w_psel[2];
    assign apb_request_2__penable = w_penable[2];

    assign apb_request_3__paddr   = r_paddr;
    assign apb_request_3__pwrite  = r_pwrite;
    assign apb_request_3__pwdata  = r_pwdata;
    assign apb_request_3__psel    = w_psel[3];
    assign apb_request_3__penable = w_penable[3];

endmodule
